ras_circ: RTL and testbench
===========================

# ras_circ

Parametrised circular return-address stack for the CVA6 frontend. It generalises the fixed two-entry RAS to any power-of-two depth and any address width. On overflow it wraps and overwrites the oldest entry instead of dropping the push. It also adds simultaneous push+pop (replace) and a checkpoint/restore path for misprediction recovery. It sits beside the BTB/BHT in the branch-prediction stage: pushes on predicted calls, pops on predicted returns.

## Interface
- DEPTH, default 4: number of entries; power of two, ≥2.
- VLEN, default 32: return-address width in bits.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  empty the stack (pipeline flush).
- push_i  in  1  push data_i (predicted call).
- pop_i  in  1  pop top (predicted return).
- data_i  in  VLEN  return address to push.
- ckpt_save_i  in  1  capture checkpoint.
- ckpt_restore_i  in  1  restore last checkpoint.
- data_o  out  VLEN  top-of-stack address; '0 when empty.
- valid_o  out  1  stack non-empty.
- count_o  out  $clog2(DEPTH+1)  occupancy, 0..DEPTH.
- overflow_o  out  1  registered pulse: last cycle's push overwrote the oldest entry.
- underflow_o  out  1  registered pulse: last cycle's pop hit an empty stack.

## Operation
- State: mem[DEPTH] of VLEN bits, top pointer ptr ($clog2(DEPTH) bits, mod DEPTH), count.
- Priority per cycle: flush_i > ckpt_restore_i > push/pop.
- flush_i: ptr←0, count←0, mem unchanged; push/pop/restore ignored.
- Push only: ptr←ptr+1 mod DEPTH; mem[ptr+1]←data_i; count←min(count+1, DEPTH).
  - If count==DEPTH, overflow_o pulses next cycle.
- Pop only, count>0: ptr←ptr−1 mod DEPTH; count←count−1.
- Pop only, count==0: no state change; underflow_o pulses next cycle.
- Push+pop (replace):
  - count>0: mem[ptr]←data_i; ptr and count unchanged.
  - count==0: behaves as a push; no underflow.
- Checkpoint register holds {ptr, count, top value}.
- ckpt_save_i captures this cycle's next-state {ptr_n, count_n, mem_n[ptr_n]}.
  - Ignored when flush_i or ckpt_restore_i is high.
- ckpt_restore_i: ptr←ckpt.ptr; count←ckpt.count; mem[ckpt.ptr]←ckpt.top.
  - This repairs a wrong-path replace or overwrite of the top entry; deeper entries are not repaired.
  - Restore before any save returns the reset checkpoint (all zero): empty stack.
- Outputs:
  - data_o = valid_o ? mem[ptr] : '0.
  - valid_o = (count≠0).
  - count_o = count.

## Timing
- data_o, valid_o and count_o are combinational from registers only; no input→output path.
- Every operation is visible on the outputs the cycle after the input is sampled (1-cycle latency).
- overflow_o and underflow_o are registered, high for exactly one cycle.
- Reset values: mem all '0, ptr 0, count 0, checkpoint all '0, data_o '0, valid_o 0, count_o 0, overflow_o 0, underflow_o 0.
- Reset mid-operation clears everything immediately, including the checkpoint.
- Wrap-around: ptr arithmetic is mod DEPTH, so DEPTH−1+1→0 and 0−1→DEPTH−1.
- count saturates at DEPTH and never goes below 0.
- Back-to-back pushes, pops and replaces are accepted every cycle; there is no stall or ready handshake.

## Configuration
- Macro RAS_CIRC_CKPT_EN.
- Defined: checkpoint register and save/restore behaviour are present as described.
- Undefined: no checkpoint register is built; ckpt_save_i and ckpt_restore_i remain as ports but are ignored, and priority reduces to flush_i > push/pop.

## Structure
- Shared package ras_circ_pkg holds:
  - enum ras_op_e {RAS_NONE, RAS_PUSH, RAS_POP, RAS_REPLACE}, decoded from push_i/pop_i;
  - localparam RAS_MIN_DEPTH = 2, used by an elaboration-time check that DEPTH is a power of two ≥ RAS_MIN_DEPTH.
- The checkpoint type depends on DEPTH and VLEN, so it is a localparam type inside the module.
- No sub-module: storage, pointer and checkpoint logic form one flat module.

## Test plan
- DEPTH=4, push 0x100, 0x200, 0x300 → count_o=3, data_o=0x300. Then pop ×3 → data_o 0x200, 0x100, then valid_o=0 and data_o=0.
- Push 0xA..0xE (5 pushes) → overflow_o pulses on the cycle after the 5th push, count_o=4. Then pop ×4 → data_o 0xD, 0xC, 0xB, then empty; 0xA is lost.
- Empty stack, pop → underflow_o=1 for one cycle, count_o=0, ptr unchanged. A following push of 0x40 gives data_o=0x40.
- Stack [0x10, 0x20], push+pop with 0x99 → data_o=0x99, count_o=2. A following pop → data_o=0x10.
- With RAS_CIRC_CKPT_EN: stack [0x10, 0x20], save, then replace 0x77 and push 0x88 → restore gives data_o=0x20, count_o=2. Without the macro, the same stimulus ends at data_o=0x88, count_o=3.
- Stack [0x10, 0x20], flush, restore and push all in the same cycle → count_o=0, valid_o=0. Deasserting rst_ni mid-sequence clears all outputs immediately.

Source files
------------

// File: rtl/ras_circ_pkg.sv
// ras_circ_pkg: shared op encoding, depth limit and op decoder for the circular return-address stack
package ras_circ_pkg;
  typedef enum logic [1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_REPLACE} ras_op_e;
  localparam int RAS_MIN_DEPTH = 2;
  function automatic ras_op_e ras_decode(input logic push, input logic pop);
    return push && pop ? RAS_REPLACE : push ? RAS_PUSH : pop ? RAS_POP : RAS_NONE;
  endfunction
endpackage

// File: rtl/ras_circ.sv
// ras_circ: parametrised circular return-address stack with wrap-on-overflow, replace and optional checkpoint/restore
// Ports: clk_i/rst_ni (async active-low), flush_i, push_i, pop_i, data_i, ckpt_save_i, ckpt_restore_i
//        -> data_o (top or 0), valid_o, count_o, overflow_o/underflow_o (registered one-cycle pulses).
// Macro RAS_CIRC_CKPT_EN builds the checkpoint register; without it the checkpoint inputs are ignored.
module ras_circ
  import ras_circ_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int VLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [VLEN-1:0]            data_i,
  input  logic                       ckpt_save_i,
  input  logic                       ckpt_restore_i,
  output logic [VLEN-1:0]            data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  if (DEPTH < RAS_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ras_circ: DEPTH must be a power of two >= RAS_MIN_DEPTH");
  end
  logic [VLEN-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, ptr_n, waddr;
  logic [CW-1:0] cnt, cnt_n;
  logic [VLEN-1:0] wdata;
  logic we, ovf_n, unf_n, empty, full;
  ras_op_e op;
  assign op = ras_decode(push_i, pop_i);
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
`ifdef RAS_CIRC_CKPT_EN
  localparam type ckpt_t = struct packed {
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [VLEN-1:0] top;
  };
  ckpt_t ckpt;
  logic [VLEN-1:0] top_n;
`else
  logic unused_ckpt;
  assign unused_ckpt = ckpt_save_i | ckpt_restore_i;
`endif
  always_comb begin
    ptr_n = ptr;
    cnt_n = cnt;
    we = 1'b0;
    waddr = ptr;
    wdata = data_i;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    if (flush_i) begin
      ptr_n = '0;
      cnt_n = '0;
    end
`ifdef RAS_CIRC_CKPT_EN
    else if (ckpt_restore_i) begin
      ptr_n = ckpt.ptr;
      cnt_n = ckpt.cnt;
      we = 1'b1;
      waddr = ckpt.ptr;
      wdata = ckpt.top;
    end
`endif
    // a replace on an empty stack has no top to overwrite, so it degrades to a push
    else if (op == RAS_PUSH || (op == RAS_REPLACE && empty)) begin
      ptr_n = ptr + 1'b1;
      waddr = ptr + 1'b1;
      we = 1'b1;
      cnt_n = full ? cnt : cnt + 1'b1;
      ovf_n = full;
    end
    else if (op == RAS_REPLACE) begin
      we = 1'b1;
    end
    else if (op == RAS_POP) begin
      ptr_n = empty ? ptr : ptr - 1'b1;
      cnt_n = empty ? cnt : cnt - 1'b1;
      unf_n = empty;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr <= '0;
      cnt <= '0;
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (we) mem[waddr] <= wdata;
      ptr <= ptr_n;
      cnt <= cnt_n;
      overflow_o <= ovf_n;
      underflow_o <= unf_n;
    end
  end
`ifdef RAS_CIRC_CKPT_EN
  // capture the post-update top so the snapshot matches what the stack will show next cycle
  assign top_n = (we && waddr == ptr_n) ? wdata : mem[ptr_n];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ckpt <= '0;
    else if (ckpt_save_i && !flush_i && !ckpt_restore_i) ckpt <= '{ptr: ptr_n, cnt: cnt_n, top: top_n};
  end
`endif
  assign valid_o = !empty;
  assign count_o = cnt;
  assign data_o = valid_o ? mem[ptr] : '0;
endmodule

// File: tb/tb_ras_circ.sv
// tb_ras_circ: directed self-checking bench for ras_circ (DEPTH=4, VLEN=32)
module tb_ras_circ;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, push = 1'b0, pop = 1'b0, save = 1'b0, restore = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic valid, ovf, unf;
  logic [2:0] count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ras_circ #(.DEPTH(4), .VLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop), .data_i(din),
    .ckpt_save_i(save), .ckpt_restore_i(restore), .data_o(dout), .valid_o(valid),
    .count_o(count), .overflow_o(ovf), .underflow_o(unf)
  );
  task automatic cyc(input logic p, input logic q, input logic [31:0] d, input logic s, input logic r, input logic f);
    push = p; pop = q; din = d; save = s; restore = r; flush = f;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; din = '0; save = 1'b0; restore = 1'b0; flush = 1'b0;
  endtask
  task automatic test_reset;
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", dout); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({ovf, unf} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {ovf, unf}); end
  endtask
  task automatic test_push_pop;
    cyc(1, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 32'h200, 0, 0, 0);
    cyc(1, 0, 32'h300, 0, 0, 0);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL pp_count got=%0d exp=3", count); end
    checks++; if (dout !== 32'h300) begin failures++; $display("FAIL pp_top got=%h exp=300", dout); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (dout !== 32'h200) begin failures++; $display("FAIL pp_pop1 got=%h exp=200", dout); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (dout !== 32'h100) begin failures++; $display("FAIL pp_pop2 got=%h exp=100", dout); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if ({valid, dout} !== 33'h0) begin failures++; $display("FAIL pp_empty got=%b/%h exp=0/0", valid, dout); end
  endtask
  task automatic test_overflow;
    for (int i = 0; i < 5; i++) begin
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_early push=%0d got=%b exp=0", i, ovf); end
      cyc(1, 0, 32'hA + i, 0, 0, 0);
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", ovf); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (dout !== 32'hE) begin failures++; $display("FAIL ovf_top got=%h exp=e", dout); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", ovf); end
    checks++; if (dout !== 32'hD) begin failures++; $display("FAIL ovf_pop1 got=%h exp=d", dout); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (dout !== 32'hC) begin failures++; $display("FAIL ovf_pop2 got=%h exp=c", dout); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (dout !== 32'hB) begin failures++; $display("FAIL ovf_pop3 got=%h exp=b", dout); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if ({valid, count, dout} !== 36'h0) begin failures++; $display("FAIL ovf_lost got=%b/%0d/%h exp=0/0/0", valid, count, dout); end
  endtask
  task automatic test_underflow;
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (unf !== 1'b1) begin failures++; $display("FAIL unf_pulse got=%b exp=1", unf); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", count); end
    cyc(1, 0, 32'h40, 0, 0, 0);
    checks++; if (unf !== 1'b0) begin failures++; $display("FAIL unf_one_cycle got=%b exp=0", unf); end
    checks++; if (dout !== 32'h40 || count !== 3'd1) begin failures++; $display("FAIL unf_push got=%h/%0d exp=40/1", dout, count); end
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 32'h41, 0, 0, 0);
    checks++; if (dout !== 32'h41 || count !== 3'd1 || unf !== 1'b0) begin failures++; $display("FAIL replace_empty got=%h/%0d/%b exp=41/1/0", dout, count, unf); end
  endtask
  task automatic test_back_to_back;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 0, 0, 0);
    cyc(1, 0, 32'h20, 0, 0, 0);
    cyc(1, 1, 32'h99, 0, 0, 0);
    checks++; if (dout !== 32'h99 || count !== 3'd2) begin failures++; $display("FAIL replace got=%h/%0d exp=99/2", dout, count); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (dout !== 32'h10 || count !== 3'd1) begin failures++; $display("FAIL replace_pop got=%h/%0d exp=10/1", dout, count); end
  endtask
  task automatic test_checkpoint;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 0, 0, 0);
    cyc(1, 0, 32'h20, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 1, 32'h77, 0, 0, 0);
    cyc(1, 0, 32'h88, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
`ifdef RAS_CIRC_CKPT_EN
    checks++; if (dout !== 32'h20 || count !== 3'd2) begin failures++; $display("FAIL ckpt_restore got=%h/%0d exp=20/2", dout, count); end
`else
    checks++; if (dout !== 32'h88 || count !== 3'd3) begin failures++; $display("FAIL ckpt_ignored got=%h/%0d exp=88/3", dout, count); end
`endif
  endtask
  task automatic test_flush_priority;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 0, 0, 0);
    cyc(1, 0, 32'h20, 0, 0, 0);
    cyc(1, 0, 32'h30, 0, 1, 1);
    checks++; if ({valid, count, dout} !== 36'h0) begin failures++; $display("FAIL flush_prio got=%b/%0d/%h exp=0/0/0", valid, count, dout); end
  endtask
  task automatic test_async_reset;
    cyc(1, 0, 32'h55, 0, 0, 0);
    cyc(1, 0, 32'h66, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (unf !== 1'b0) begin failures++; $display("FAIL pre_reset_unf got=%b exp=0", unf); end
    cyc(0, 1, 0, 0, 0, 0);
    checks++; if (unf !== 1'b1) begin failures++; $display("FAIL pre_reset_unf2 got=%b exp=1", unf); end
    rst_n = 1'b0;
    #1;
    checks++; if ({valid, count, dout, ovf, unf} !== 38'h0) begin failures++; $display("FAIL async_reset got=%b/%0d/%h/%b/%b exp=all 0", valid, count, dout, ovf, unf); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 32'h55, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
`ifdef RAS_CIRC_CKPT_EN
    checks++; if ({valid, count, dout} !== 36'h0) begin failures++; $display("FAIL restore_after_reset got=%b/%0d/%h exp=0/0/0", valid, count, dout); end
`else
    checks++; if (dout !== 32'h55 || count !== 3'd1) begin failures++; $display("FAIL restore_ignored got=%h/%0d exp=55/1", dout, count); end
`endif
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_reset;
    test_push_pop;
    test_overflow;
    test_underflow;
    test_back_to_back;
    test_checkpoint;
    test_flush_priority;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
